// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

   localparam int unsigned LARGURA_PADRAO       = 16;
   localparam int unsigned CANAIS_PADRAO        = 4;
   localparam int unsigned PRESC_LARGURA_PADRAO = 8;

   // Low bit index of channel 'canal' inside the packed duty vector.
   function automatic int unsigned lsb_canal(input int unsigned canal,
                                             input int unsigned largura);
      return canal * largura;
   endfunction

endpackage

// File: rtl/divisor_prescaler.sv
// Prescaler tick generator: one tick every prescaler+1 clocks while enabled.
module divisor_prescaler #(
   parameter int unsigned PRESC_LARGURA = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     habilita,
   input  logic [PRESC_LARGURA-1:0] prescaler,
   output logic                     tick
);

   logic [PRESC_LARGURA-1:0] conta_q, conta_d;

   // Tick at the limit; '>=' keeps the count bounded even if the limit shrinks.
   always_comb begin
      tick    = 1'b0;
      conta_d = conta_q;
      if (!habilita) begin
         conta_d = '0;
      end else if (conta_q >= prescaler) begin
         tick    = 1'b1;
         conta_d = '0;
      end else begin
         conta_d = conta_q + 1'b1;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conta_q <= '0;
      end else begin
         conta_q <= conta_d;
      end
   end

endmodule

// File: rtl/pwm_multicanal.sv
// Multi-channel PWM with one shared period counter and boundary-synchronous
// reload of prescaler/period/duty. Optional output inversion: PWM_INVERSAO_EN.
module pwm_multicanal
   import pwm_pkg::*;
#(
   parameter int unsigned LARGURA       = LARGURA_PADRAO,
   parameter int unsigned CANAIS        = CANAIS_PADRAO,
   parameter int unsigned PRESC_LARGURA = PRESC_LARGURA_PADRAO
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       habilita,
   input  logic [PRESC_LARGURA-1:0]   prescaler,
   input  logic [LARGURA-1:0]         periodo,
   input  logic [CANAIS*LARGURA-1:0]  ciclo,
   input  logic                       carrega,
`ifdef PWM_INVERSAO_EN
   input  logic [CANAIS-1:0]          polaridade,
`endif
   output logic                       pendente,
   output logic                       fim_periodo,
   output logic [CANAIS-1:0]          saida
);

   logic [PRESC_LARGURA-1:0]  presc_a_q, presc_a_d;
   logic [LARGURA-1:0]        per_a_q, per_a_d;
   logic [CANAIS*LARGURA-1:0] ciclo_a_q, ciclo_a_d;
   logic [LARGURA-1:0]        cont_q, cont_d;
   logic                      pend_q, pend_d;
   logic                      fim_q, fim_d;
   logic [CANAIS-1:0]         saida_q, saida_d;
   logic [CANAIS-1:0]         inversao;
   logic                      tick;
   logic                      wrap;
   logic                      carga;

`ifdef PWM_INVERSAO_EN
   assign inversao = polaridade;
`else
   assign inversao = '0;
`endif

   divisor_prescaler #(
      .PRESC_LARGURA (PRESC_LARGURA)
   ) u_divisor (
      .clock     (clock),
      .reset     (reset),
      .habilita  (habilita),
      .prescaler (presc_a_q),
      .tick      (tick)
   );

   // Period counter, reload control and per-channel comparison.
   always_comb begin
      wrap      = tick && (cont_q >= per_a_q);
      cont_d    = cont_q;
      pend_d    = pend_q;
      carga     = 1'b0;
      presc_a_d = presc_a_q;
      per_a_d   = per_a_q;
      ciclo_a_d = ciclo_a_q;
      saida_d   = '0;

      if (!habilita) begin
         cont_d = '0;
         pend_d = 1'b0;
         carga  = 1'b1;
      end else begin
         if (tick) begin
            cont_d = wrap ? '0 : cont_q + 1'b1;
         end
         // A request arriving on the wrap clock is applied at that same wrap.
         if (wrap && (pend_q || carrega)) begin
            carga  = 1'b1;
            pend_d = 1'b0;
         end else if (carrega) begin
            pend_d = 1'b1;
         end
      end

      if (carga) begin
         presc_a_d = prescaler;
         per_a_d   = periodo;
         ciclo_a_d = ciclo;
      end

      fim_d = wrap;

      // Compare against the post-edge counter and post-edge active duty.
      for (int unsigned i = 0; i < CANAIS; i++) begin
         saida_d[i] = (habilita && (cont_d < ciclo_a_d[lsb_canal(i, LARGURA) +: LARGURA]))
                      ^ inversao[i];
      end
   end

   // State and active-copy registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_a_q <= '0;
         per_a_q   <= '0;
         ciclo_a_q <= '0;
         cont_q    <= '0;
         pend_q    <= 1'b0;
         fim_q     <= 1'b0;
         saida_q   <= '0;
      end else begin
         presc_a_q <= presc_a_d;
         per_a_q   <= per_a_d;
         ciclo_a_q <= ciclo_a_d;
         cont_q    <= cont_d;
         pend_q    <= pend_d;
         fim_q     <= fim_d;
         saida_q   <= saida_d;
      end
   end

   assign pendente    = pend_q;
   assign fim_periodo = fim_q;
   assign saida       = saida_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Self-checking bench for pwm_multicanal: table of steady-state vectors plus
// directed sequences for reload, wrap-coincident reload and async reset.
module tb_pwm_multicanal;

   logic        clock;
   logic        reset;
   logic        habilita;
   logic [7:0]  prescaler;
   logic [15:0] periodo;
   logic [63:0] ciclo;
   logic        carrega;
`ifdef PWM_INVERSAO_EN
   logic [3:0]  polaridade;
`endif
   logic        pendente;
   logic        fim_periodo;
   logic [3:0]  saida;

   int checks;
   int failures;

   pwm_multicanal #(
      .LARGURA       (16),
      .CANAIS        (4),
      .PRESC_LARGURA (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .habilita    (habilita),
      .prescaler   (prescaler),
      .periodo     (periodo),
      .ciclo       (ciclo),
      .carrega     (carrega),
`ifdef PWM_INVERSAO_EN
      .polaridade  (polaridade),
`endif
      .pendente    (pendente),
      .fim_periodo (fim_periodo),
      .saida       (saida)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]        presc;
      logic [15:0]       per;
      logic [3:0][15:0]  cic;
      logic [15:0]       janela;
      logic [3:0][15:0]  alto;
      logic [15:0]       fim;
   } vetor_t;

   vetor_t tabela [5];

   task automatic check(input string nome, input int obtido, input int esperado);
      checks++;
      if (obtido != esperado) begin
         failures++;
         $display("FAIL %s: obtido=%0d esperado=%0d", nome, obtido, esperado);
      end
   endtask

   // Load config with habilita low for two clocks, then enable.
   task automatic configura(input logic [7:0] p, input logic [15:0] per, input logic [63:0] c);
      @(negedge clock);
      habilita  = 1'b0;
      carrega   = 1'b0;
      prescaler = p;
      periodo   = per;
      ciclo     = c;
      repeat (2) @(negedge clock);
      habilita = 1'b1;
   endtask

   // Clocks until next fim_periodo sample; -1 on timeout.
   task automatic espera_fim(output int n, output bit pend_sempre);
      n = 0;
      pend_sempre = 1'b1;
      do begin
         @(negedge clock);
         n++;
         if (!fim_periodo && !pendente) pend_sempre = 1'b0;
      end while (!fim_periodo && n < 200);
      if (!fim_periodo) n = -1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: obtido=timeout esperado=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit ps;
      int alto [4];
      int fims;

      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      habilita  = 1'b0;
      prescaler = '0;
      periodo   = '0;
      ciclo     = '0;
      carrega   = 1'b0;
`ifdef PWM_INVERSAO_EN
      polaridade = '0;
`endif

      tabela[0] = '{presc: 8'd0, per: 16'd9, cic: {16'd7, 16'd10, 16'd0, 16'd3},
                    janela: 16'd20, alto: {16'd14, 16'd20, 16'd0, 16'd6}, fim: 16'd2};
      tabela[1] = '{presc: 8'd3, per: 16'd4, cic: {16'd1, 16'd5, 16'd2, 16'd0},
                    janela: 16'd40, alto: {16'd8, 16'd40, 16'd16, 16'd0}, fim: 16'd2};
      tabela[2] = '{presc: 8'd0, per: 16'd5, cic: {16'd65535, 16'd6, 16'd5, 16'd0},
                    janela: 16'd12, alto: {16'd12, 16'd12, 16'd10, 16'd0}, fim: 16'd2};
      tabela[3] = '{presc: 8'd0, per: 16'd0, cic: {16'd0, 16'd2, 16'd1, 16'd0},
                    janela: 16'd4, alto: {16'd0, 16'd4, 16'd4, 16'd0}, fim: 16'd4};
      tabela[4] = '{presc: 8'd2, per: 16'd0, cic: {16'd0, 16'd0, 16'd0, 16'd1},
                    janela: 16'd6, alto: {16'd0, 16'd0, 16'd0, 16'd6}, fim: 16'd2};

      // Reset state.
      repeat (3) @(negedge clock);
      check("reset_saida", saida, 0);
      check("reset_fim", fim_periodo, 0);
      check("reset_pendente", pendente, 0);
      reset = 1'b1;

      // Steady-state table: count high clocks and wraps over whole periods.
      for (int k = 0; k < 5; k++) begin
         configura(tabela[k].presc, tabela[k].per, tabela[k].cic);
         repeat (tabela[k].janela) @(negedge clock);
         for (int i = 0; i < 4; i++) alto[i] = 0;
         fims = 0;
         for (int t = 0; t < int'(tabela[k].janela); t++) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) alto[i] += int'(saida[i]);
            fims += int'(fim_periodo);
         end
         for (int i = 0; i < 4; i++)
            check($sformatf("vetor%0d_alto_canal%0d", k, i), alto[i], tabela[k].alto[i]);
         check($sformatf("vetor%0d_fim", k), fims, tabela[k].fim);
      end

      // Mid-period reload: pending until the wrap, then a 5-clock period.
      configura(8'd0, 16'd9, {16'd7, 16'd10, 16'd0, 16'd3});
      espera_fim(n, ps);
      repeat (3) @(negedge clock);
      periodo = 16'd4;
      carrega = 1'b1;
      @(negedge clock);
      carrega = 1'b0;
      check("recarga_pendente_set", pendente, 1);
      espera_fim(n, ps);
      check("recarga_pendente_ate_wrap", ps, 1);
      check("recarga_pendente_limpo", pendente, 0);
      espera_fim(n, ps);
      check("recarga_novo_periodo", n, 5);

      // Input change without carrega has no effect.
      periodo = 16'd9;
      espera_fim(n, ps);
      check("sem_carrega_periodo", n, 5);

      // carrega on the wrap clock: applied at that wrap, nothing left pending.
      repeat (4) @(negedge clock);
      periodo = 16'd7;
      carrega = 1'b1;
      @(negedge clock);
      carrega = 1'b0;
      check("carrega_no_wrap_fim", fim_periodo, 1);
      check("carrega_no_wrap_pendente", pendente, 0);
      espera_fim(n, ps);
      check("carrega_no_wrap_periodo", n, 8);

      // Asynchronous reset at counter=6 with a pending load.
      configura(8'd0, 16'd9, {16'd7, 16'd10, 16'd0, 16'd3});
      espera_fim(n, ps);
      repeat (5) @(negedge clock);
      carrega = 1'b1;
      @(negedge clock);
      carrega = 1'b0;
      check("pre_reset_saida", saida, 4'b1100);
      check("pre_reset_pendente", pendente, 1);
      #1;
      reset = 1'b0;
      #1;
      check("reset_async_saida", saida, 0);
      check("reset_async_fim", fim_periodo, 0);
      check("reset_async_pendente", pendente, 0);
      @(negedge clock);
      habilita = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      habilita = 1'b1;
      espera_fim(n, ps);
      check("pos_reset_primeiro_wrap", n, 10);

      // Disabled: outputs idle and pending request discarded.
      @(negedge clock);
      habilita = 1'b0;
      carrega  = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_saida", saida, 0);
      check("idle_fim", fim_periodo, 0);
      check("idle_pendente", pendente, 0);
      carrega = 1'b0;

`ifdef PWM_INVERSAO_EN
      // Inverted channel 0: low 3 of 10, idle high.
      polaridade = 4'b0001;
      configura(8'd0, 16'd9, {16'd0, 16'd0, 16'd0, 16'd3});
      repeat (10) @(negedge clock);
      alto[0] = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         alto[0] += int'(saida[0]);
      end
      check("inversao_alto_canal0", alto[0], 14);
      habilita = 1'b0;
      repeat (2) @(negedge clock);
      check("inversao_idle_canal0", saida[0], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
